prog_sequencer: RTL and testbench

Batch run controller that sits directly upstream of the processor top level and drives its `Start` input while monitoring its `Ack` (done) output. On a `Go` request it runs programs 0..`LastProg` back to back. For each program it:
- pulses the DUT start line;
- counts execution cycles until `Ack`;
- publishes the count with a one-cycle valid strobe.

It is the handshake partner of the processor core in both the system bench and the FPGA wrapper.

---
 rtl/prog_sequencer_if.sv | 29 ++
 rtl/prog_sequencer.sv | 146 ++++++++++++++
 tb/tb_prog_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// Host/processor handshake bundle for prog_sequencer: batch request and
// result strobe on the host side, Start/Ack on the processor side.
interface prog_sequencer_if #(
  parameter int NPROG_W = 2,
  parameter int CNT_W   = 16
);
  logic               Go;
  logic [NPROG_W-1:0] LastProg;
  logic               DutAck;
  logic               DutStart;
  logic [NPROG_W-1:0] ProgSel;
  logic [CNT_W-1:0]   CycleCt;
  logic               CycleValid;
  logic               Busy;
  logic               AllDone;
  logic               TimedOut;

  // The sequencer itself.
  modport slave (
    input  Go, LastProg, DutAck,
    output DutStart, ProgSel, CycleCt, CycleValid, Busy, AllDone, TimedOut
  );

  // Whatever drives the batch request and plays the processor.
  modport master (
    output Go, LastProg, DutAck,
    input  DutStart, ProgSel, CycleCt, CycleValid, Busy, AllDone, TimedOut
  );
endinterface

// File: rtl/prog_sequencer.sv
// Batch run controller: starts programs 0..LastProg back to back and reports
// per-program cycle counts. Watchdog enabled by defining PROG_SEQ_TIMEOUT_EN.
module prog_sequencer #(
  parameter int NPROG_W   = 2,
  parameter int CNT_W     = 16,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input logic            Clk,
  input logic            Reset,
  prog_sequencer_if.slave bus
);

  localparam int SC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               dut_start_q, dut_start_d;
  logic [NPROG_W-1:0] prog_sel_q, prog_sel_d;
  logic [NPROG_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]   cycle_ct_q, cycle_ct_d;
  logic               cycle_valid_q, cycle_valid_d;
  logic               busy_q, busy_d;
  logic               all_done_q, all_done_d;
  logic               timed_out_q, timed_out_d;
  logic [SC_W-1:0]    sc_q, sc_d;
  logic [CNT_W-1:0]   rc_q, rc_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    dut_start_d   = dut_start_q;
    prog_sel_d    = prog_sel_q;
    last_d        = last_q;
    cycle_ct_d    = cycle_ct_q;
    cycle_valid_d = 1'b0;
    busy_d        = busy_q;
    all_done_d    = all_done_q;
    timed_out_d   = timed_out_q;
    sc_d          = sc_q;
    rc_d          = rc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_IDLE) begin
          prog_sel_d  = '0;
          timed_out_d = 1'b0;
        end
        if (bus.Go) begin
          state_d     = S_START;
          dut_start_d = 1'b1;
          busy_d      = 1'b1;
          all_done_d  = 1'b0;
          prog_sel_d  = '0;
          last_d      = bus.LastProg;
          timed_out_d = 1'b0;
          sc_d        = '0;
        end
      end
      S_START: begin
        // Ack is deliberately not looked at here: it may still be high from the previous program.
        if (sc_q == SC_W'(START_CYC - 1)) begin
          state_d     = S_RUN;
          dut_start_d = 1'b0;
          rc_d        = '0;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.DutAck) begin
          state_d       = S_GAP;
          cycle_ct_d    = rc_q;
          cycle_valid_d = 1'b1;
`ifdef PROG_SEQ_TIMEOUT_EN
        end else if (rc_q == CNT_W'(TIMEOUT)) begin
          state_d       = S_GAP;
          cycle_ct_d    = CNT_W'(TIMEOUT);
          cycle_valid_d = 1'b1;
          timed_out_d   = 1'b1;
`endif
        end else if (rc_q != '1) begin
          rc_d = rc_q + 1'b1;
        end
      end
      S_GAP: begin
        if (prog_sel_q == last_q) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          all_done_d = 1'b1;
        end else begin
          state_d     = S_START;
          prog_sel_d  = prog_sel_q + 1'b1;
          dut_start_d = 1'b1;
          sc_d        = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      dut_start_q   <= 1'b0;
      prog_sel_q    <= '0;
      last_q        <= '0;
      cycle_ct_q    <= '0;
      cycle_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      sc_q          <= '0;
      rc_q          <= '0;
    end else begin
      state_q       <= state_d;
      dut_start_q   <= dut_start_d;
      prog_sel_q    <= prog_sel_d;
      last_q        <= last_d;
      cycle_ct_q    <= cycle_ct_d;
      cycle_valid_q <= cycle_valid_d;
      busy_q        <= busy_d;
      all_done_q    <= all_done_d;
      timed_out_q   <= timed_out_d;
      sc_q          <= sc_d;
      rc_q          <= rc_d;
    end
  end

  assign bus.DutStart   = dut_start_q;
  assign bus.ProgSel    = prog_sel_q;
  assign bus.CycleCt    = cycle_ct_q;
  assign bus.CycleValid = cycle_valid_q;
  assign bus.Busy       = busy_q;
  assign bus.AllDone    = all_done_q;
  assign bus.TimedOut   = timed_out_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: plays the processor side (Start/Ack)
// with hand-picked Ack latencies and checks strobes, counts and state flags.
module tb_prog_sequencer;

  localparam int NPROG_W   = 2;
  localparam int CNT_W     = 16;
  localparam int START_CYC = 2;
  localparam int TIMEOUT   = 64;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  prog_sequencer_if #(.NPROG_W(NPROG_W), .CNT_W(CNT_W)) bus ();

  prog_sequencer #(
    .NPROG_W(NPROG_W), .CNT_W(CNT_W), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_batch(input logic [NPROG_W-1:0] last);
    bus.Go       = 1'b1;
    bus.LastProg = last;
    tick();
    bus.Go = 1'b0;
  endtask

  // One program: optional stale Ack during START, Ack after `lat` quiet RUN
  // cycles, optional Go/LastProg poke during RUN. Returns in cycle m+2.
  task automatic do_program(input int lat, input int prog, input bit stale, input bit poke);
    int n;
    n = 0;
    while (bus.DutStart !== 1'b1 && n < 10) begin tick(); n++; end
    total++; if (bus.DutStart !== 1'b1) begin bad++; $display("FAIL start_rise prog=%0d: DutStart=%b want 1", prog, bus.DutStart); end
    n = 0;
    while (bus.DutStart === 1'b1 && n < 20) begin bus.DutAck = stale; tick(); n++; end
    total++; if (n != START_CYC) begin bad++; $display("FAIL start_len prog=%0d: got %0d cycles want %0d", prog, n, START_CYC); end
    for (int i = 0; i < lat; i++) begin
      bus.DutAck = 1'b0;
      if (poke) begin
        bus.Go = (i == 1);
        if (i == 1) bus.LastProg = 2'd3;
      end
      tick();
    end
    bus.Go     = 1'b0;
    bus.DutAck = 1'b1;
    tick();
    bus.DutAck = 1'b0;
    total++; if (bus.CycleValid !== 1'b1) begin bad++; $display("FAIL strobe prog=%0d: CycleValid=%b want 1", prog, bus.CycleValid); end
    total++; if (bus.CycleCt !== CNT_W'(lat)) begin bad++; $display("FAIL count prog=%0d: CycleCt=%0d want %0d", prog, bus.CycleCt, lat); end
    total++; if (bus.ProgSel !== NPROG_W'(prog)) begin bad++; $display("FAIL progsel prog=%0d: ProgSel=%0d want %0d", prog, bus.ProgSel, prog); end
    tick();
    total++; if (bus.CycleValid !== 1'b0) begin bad++; $display("FAIL strobe_len prog=%0d: CycleValid=%b want 0", prog, bus.CycleValid); end
  endtask

  task automatic expect_next(input int prog);
    total++; if (bus.DutStart !== 1'b1 || bus.ProgSel !== NPROG_W'(prog)) begin
      bad++; $display("FAIL next_start: DutStart=%b ProgSel=%0d want 1/%0d", bus.DutStart, bus.ProgSel, prog);
    end
  endtask

  task automatic expect_done(input int prog);
    total++; if (bus.AllDone !== 1'b1 || bus.Busy !== 1'b0 || bus.DutStart !== 1'b0 || bus.ProgSel !== NPROG_W'(prog)) begin
      bad++; $display("FAIL done: AllDone=%b Busy=%b DutStart=%b ProgSel=%0d want 1/0/0/%0d",
                      bus.AllDone, bus.Busy, bus.DutStart, bus.ProgSel, prog);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; bus.Go = 1'b0; bus.LastProg = '0; bus.DutAck = 1'b0;
    #3;
    total++; if ({bus.DutStart, bus.ProgSel, bus.CycleCt, bus.CycleValid, bus.Busy, bus.AllDone, bus.TimedOut} !== '0) begin
      bad++; $display("FAIL reset_vals: DutStart=%b ProgSel=%0d CycleCt=%0d CycleValid=%b Busy=%b AllDone=%b TimedOut=%b want all 0",
                      bus.DutStart, bus.ProgSel, bus.CycleCt, bus.CycleValid, bus.Busy, bus.AllDone, bus.TimedOut);
    end
    tick(); tick();
    Reset = 1'b0;
    tick(); tick();
    total++; if (bus.Busy !== 1'b0 || bus.DutStart !== 1'b0 || bus.AllDone !== 1'b0) begin
      bad++; $display("FAIL idle_hold: Busy=%b DutStart=%b AllDone=%b want 0/0/0", bus.Busy, bus.DutStart, bus.AllDone);
    end
  endtask

  task automatic test_single();
    start_batch(2'd0);
    total++; if (bus.Busy !== 1'b1) begin bad++; $display("FAIL busy_rise: Busy=%b want 1", bus.Busy); end
    do_program(10, 0, 1'b0, 1'b0);
    expect_done(0);
    tick(); tick(); tick();
    total++; if (bus.AllDone !== 1'b1 || bus.CycleCt !== 16'd10) begin
      bad++; $display("FAIL done_hold: AllDone=%b CycleCt=%0d want 1/10", bus.AllDone, bus.CycleCt);
    end
  endtask

  task automatic test_three();
    start_batch(2'd2);
    total++; if (bus.AllDone !== 1'b0) begin bad++; $display("FAIL alldone_drop: AllDone=%b want 0", bus.AllDone); end
    do_program(5, 0, 1'b0, 1'b0);  expect_next(1);
    do_program(0, 1, 1'b0, 1'b0);  expect_next(2);
    do_program(33, 2, 1'b0, 1'b0); expect_done(2);
  endtask

  task automatic test_stale_ack();
    start_batch(2'd0);
    do_program(7, 0, 1'b1, 1'b0);
    expect_done(0);
  endtask

  task automatic test_go_busy();
    start_batch(2'd1);
    do_program(4, 0, 1'b0, 1'b1); expect_next(1);
    do_program(3, 1, 1'b0, 1'b0); expect_done(1);
    // LastProg now 3: full batch reaches the top index without wrapping.
    start_batch(2'd3);
    do_program(1, 0, 1'b0, 1'b0); expect_next(1);
    do_program(2, 1, 1'b0, 1'b0); expect_next(2);
    do_program(3, 2, 1'b0, 1'b0); expect_next(3);
    do_program(4, 3, 1'b0, 1'b0); expect_done(3);
  endtask

  task automatic test_reset_mid_run();
    start_batch(2'd2);
    do_program(2, 0, 1'b0, 1'b0); expect_next(1);
    tick(); tick();
    for (int i = 0; i < 4; i++) tick();
    total++; if (bus.ProgSel !== 2'd1 || bus.Busy !== 1'b1 || bus.DutStart !== 1'b0) begin
      bad++; $display("FAIL in_run: ProgSel=%0d Busy=%b DutStart=%b want 1/1/0", bus.ProgSel, bus.Busy, bus.DutStart);
    end
    Reset = 1'b1;
    #1;
    total++; if ({bus.DutStart, bus.ProgSel, bus.CycleCt, bus.CycleValid, bus.Busy, bus.AllDone, bus.TimedOut} !== '0) begin
      bad++; $display("FAIL async_reset: ProgSel=%0d CycleCt=%0d Busy=%b want 0/0/0", bus.ProgSel, bus.CycleCt, bus.Busy);
    end
    tick();
    Reset = 1'b0;
    tick();
    start_batch(2'd0);
    expect_next(0);
    do_program(3, 0, 1'b0, 1'b0);
    expect_done(0);
  endtask

  task automatic test_watchdog();
    int n;
    int strobes;
    start_batch(2'd1);
    n = 0;
    while (bus.DutStart === 1'b1 && n < 20) begin tick(); n++; end
`ifdef PROG_SEQ_TIMEOUT_EN
    n = 0;
    while (bus.CycleValid !== 1'b1 && n < 200) begin tick(); n++; end
    total++; if (n != TIMEOUT + 1) begin bad++; $display("FAIL wd_latency: strobe after %0d RUN cycles want %0d", n, TIMEOUT + 1); end
    total++; if (bus.CycleCt !== 16'd64 || bus.TimedOut !== 1'b1 || bus.ProgSel !== 2'd0) begin
      bad++; $display("FAIL wd_result: CycleCt=%0d TimedOut=%b ProgSel=%0d want 64/1/0", bus.CycleCt, bus.TimedOut, bus.ProgSel);
    end
    tick();
    expect_next(1);
    do_program(3, 1, 1'b0, 1'b0);
    expect_done(1);
    total++; if (bus.TimedOut !== 1'b1) begin bad++; $display("FAIL wd_sticky: TimedOut=%b want 1", bus.TimedOut); end
    start_batch(2'd0);
    total++; if (bus.TimedOut !== 1'b0) begin bad++; $display("FAIL wd_clear: TimedOut=%b want 0", bus.TimedOut); end
`else
    strobes = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.CycleValid === 1'b1) strobes++;
    end
    total++; if (strobes != 0) begin bad++; $display("FAIL no_wd_strobe: %0d strobes want 0", strobes); end
    total++; if (bus.Busy !== 1'b1 || bus.DutStart !== 1'b0 || bus.AllDone !== 1'b0 || bus.TimedOut !== 1'b0 || bus.ProgSel !== 2'd0) begin
      bad++; $display("FAIL no_wd_stuck: Busy=%b DutStart=%b AllDone=%b TimedOut=%b ProgSel=%0d want 1/0/0/0/0",
                      bus.Busy, bus.DutStart, bus.AllDone, bus.TimedOut, bus.ProgSel);
    end
`endif
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_stale_ack();
    test_go_busy();
    test_reset_mid_run();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
